// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and the byte-lane helper used by the SRAM slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  // Little-endian lane enables; illegal sizes never reach the SRAM.
  function automatic logic [3:0] be_f(input logic [1:0] addr, input logic [2:0] size);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr;
      HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-side bus bundle with master and slave views.
interface ahb_sram_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hreadyout, hresp, hrdata
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// Word-organised SRAM: asynchronous read, byte-enable synchronous write, no reset.
module ahb_slave_mem #(
  parameter  int MEM_BYTES = 1024,
  localparam int WORDS     = MEM_BYTES / 4,
  localparam int AW        = $clog2(WORDS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states and two-cycle ERROR response.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic             hclk,
  input  logic             hresetn,
  ahb_sram_slave_if.slave  bus
);

  localparam int         MEM_AW = $clog2(MEM_BYTES);
  localparam logic [3:0] WS_M1  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [MEM_AW-1:0] r_addr;
  logic              r_write;
  logic [2:0]        r_size;
  logic              w_accept;
  logic              w_err;
  logic              w_misalign;
  logic              w_we;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused_hburst;

  assign w_unused_hburst = ^bus.hburst;

  assign w_accept   = bus.hsel && bus.hready && bus.htrans[1];
  assign w_misalign = ((bus.hsize == 3'd1) && bus.haddr[0]) ||
                      ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00));
  assign w_err      = (bus.haddr >= ADDR_W'(MEM_BYTES)) || (bus.hsize > 3'd2) || w_misalign;

  // IDLE, DATA and ERR2 all sit at an address-phase boundary and share one decision.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = ST_DATA;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: begin
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
          if (w_err) begin
            w_state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WS_M1;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Address-phase attributes need no reset: they are only used while r_state is DATA.
  always_ff @(posedge hclk) begin
    if (w_accept) begin
      r_addr  <= bus.haddr[MEM_AW-1:0];
      r_write <= bus.hwrite;
      r_size  <= bus.hsize;
    end
  end

  assign w_we = (r_state == ST_DATA) && r_write;
  assign w_be = be_f(r_addr[1:0], r_size);

  ahb_slave_mem #(
    .MEM_BYTES (MEM_BYTES)
  ) u_mem (
    .i_clk   (hclk),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_addr  (r_addr[MEM_AW-1:2]),
    .i_wdata (bus.hwdata),
    .o_rdata (w_rdata)
  );

  assign bus.hreadyout = !((r_state == ST_WAIT) || (r_state == ST_ERR1));
  assign bus.hresp     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.hrdata    = (r_state == ST_DATA) ? w_rdata : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: one instance with 0 and one with 2 wait states.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  logic hclk = 1'b0;
  logic hresetn;
  always #5 hclk = ~hclk;

  ahb_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  ahb_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

  ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(1024), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hresetn(hresetn), .bus(bus0));
  ahb_sram_slave #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(1024), .WAIT_STATES(2)) dut2 (
    .hclk(hclk), .hresetn(hresetn), .bus(bus2));

  logic        t_sel;
  logic [1:0]  t_trans;
  logic        t_wr;
  logic [31:0] t_addr;
  logic [2:0]  t_size;
  logic [2:0]  t_burst;
  logic [31:0] t_wdata;
  int          which;

  assign bus0.hsel   = t_sel && (which == 0);
  assign bus0.haddr  = t_addr;
  assign bus0.htrans = t_trans;
  assign bus0.hwrite = t_wr;
  assign bus0.hsize  = t_size;
  assign bus0.hburst = t_burst;
  assign bus0.hwdata = t_wdata;
  assign bus0.hready = bus0.hreadyout;
  assign bus2.hsel   = t_sel && (which == 1);
  assign bus2.haddr  = t_addr;
  assign bus2.htrans = t_trans;
  assign bus2.hwrite = t_wr;
  assign bus2.hsize  = t_size;
  assign bus2.hburst = t_burst;
  assign bus2.hwdata = t_wdata;
  assign bus2.hready = bus2.hreadyout;

  logic        o_rdy, o_resp;
  logic [31:0] o_rdata;
  assign o_rdy   = (which == 1) ? bus2.hreadyout : bus0.hreadyout;
  assign o_resp  = (which == 1) ? bus2.hresp     : bus0.hresp;
  assign o_rdata = (which == 1) ? bus2.hrdata    : bus0.hrdata;

  typedef struct {
    logic        rd_chk;
    logic [31:0] rd;
    logic        resp;
    int          waits;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   cur_waits = 0;
  int   beat_id = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Scoreboard: the front entry describes the data phase currently on the bus.
  always @(negedge hclk) begin
    if (!hresetn) begin
      cur_waits = 0;
    end else if (sb.size() > 0) begin
      n_checks++;
      if (o_resp !== sb[0].resp) begin
        n_fail++;
        $display("FAIL hresp beat %0d: got %b, want %b", sb[0].id, o_resp, sb[0].resp);
      end
      if (!o_rdy) begin
        cur_waits++;
      end else begin
        n_checks++;
        if (cur_waits !== sb[0].waits) begin
          n_fail++;
          $display("FAIL wait_count beat %0d: got %0d, want %0d", sb[0].id, cur_waits, sb[0].waits);
        end
        if (sb[0].rd_chk) begin
          n_checks++;
          if (o_rdata !== sb[0].rd) begin
            n_fail++;
            $display("FAIL hrdata beat %0d: got %h, want %h", sb[0].id, o_rdata, sb[0].rd);
          end
        end
        void'(sb.pop_front());
        cur_waits = 0;
      end
    end
  end

  // Present one address phase, hold it until hready, then drive its write data.
  task automatic ap(input logic sel, input logic [1:0] tr, input logic wr, input logic [31:0] a,
                    input logic [2:0] sz, input logic [31:0] wd, input logic err,
                    input logic [31:0] rd);
    exp_t e;
    int   n;
    t_sel = sel; t_trans = tr; t_wr = wr; t_addr = a; t_size = sz;
    n = 0;
    do begin
      @(negedge hclk);
      n++;
    end while (!o_rdy && n < 40);
    n_checks++;
    if (!o_rdy) begin
      n_fail++;
      $display("FAIL addr_phase_timeout @%h: hreadyout got 0, want 1", a);
      return;
    end
    @(posedge hclk);
    if (sel) begin
      e.resp   = tr[1] & err;
      e.waits  = !tr[1] ? 0 : (err ? 1 : ((which == 1) ? 2 : 0));
      e.rd_chk = tr[1] & !wr & !err;
      e.rd     = rd;
      e.id     = beat_id++;
      sb.push_back(e);
    end
    #1 t_wdata = wd;
  endtask

  task automatic idle(input logic sel);
    ap(sel, HTRANS_IDLE, 1'b0, 32'h0, 3'd2, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      @(posedge hclk);
      n++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d beats still pending, want 0", sb.size());
      sb.delete();
    end
    @(posedge hclk); #1;
  endtask

  task automatic test_reset();
    t_sel = 1'b0; t_trans = HTRANS_IDLE; t_wr = 1'b0; t_addr = '0; t_size = 3'd2;
    t_burst = 3'd0; t_wdata = '0; which = 0;
    hresetn = 1'b1;
    #2 hresetn = 1'b0;
    repeat (3) @(posedge hclk);
    for (int w = 0; w < 2; w++) begin
      which = w;
      #1;
      n_checks += 3;
      if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout dut%0d: got %b, want 1", w, o_rdy); end
      if (o_resp !== 1'b0) begin n_fail++; $display("FAIL reset_hresp dut%0d: got %b, want 0", w, o_resp); end
      if (o_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata dut%0d: got %h, want 0", w, o_rdata); end
    end
    hresetn = 1'b1;
    which = 0;
    @(posedge hclk); #1;
  endtask

  task automatic test_back_to_back();
    which = 0;
    ap(1, HTRANS_NONSEQ, 1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 32'h0);
    ap(1, HTRANS_NONSEQ, 0, 32'h10, 3'd2, 32'h0, 0, 32'hDEADBEEF);
    idle(1);
    drain();
  endtask

  task automatic test_byte_half();
    which = 0;
    ap(1, HTRANS_NONSEQ, 1, 32'h13, 3'd0, 32'hAA000000, 0, 32'h0);
    ap(1, HTRANS_NONSEQ, 0, 32'h10, 3'd2, 32'h0, 0, 32'hAAADBEEF);
    ap(1, HTRANS_NONSEQ, 1, 32'h12, 3'd1, 32'h12340000, 0, 32'h0);
    ap(1, HTRANS_NONSEQ, 0, 32'h10, 3'd2, 32'h0, 0, 32'h1234BEEF);
    idle(1);
    drain();
  endtask

  task automatic test_wait_states();
    which = 1;
    ap(1, HTRANS_NONSEQ, 1, 32'h40, 3'd2, 32'h11223344, 0, 32'h0);
    ap(1, HTRANS_NONSEQ, 1, 32'h80, 3'd2, 32'hCAFEF00D, 0, 32'h0);
    ap(1, HTRANS_NONSEQ, 0, 32'h40, 3'd2, 32'h0, 0, 32'h11223344);
    // A stray write to 0x80 shown only while hready is low must be ignored.
    t_trans = HTRANS_NONSEQ; t_wr = 1'b1; t_addr = 32'h80; t_size = 3'd2; t_wdata = 32'h55555555;
    @(posedge hclk); #1;
    n_checks++;
    if (o_rdy !== 1'b0) begin n_fail++; $display("FAIL wait_hreadyout: got %b, want 0", o_rdy); end
    ap(0, HTRANS_IDLE, 0, 32'h0, 3'd2, 32'h0, 0, 32'h0);
    ap(1, HTRANS_NONSEQ, 0, 32'h80, 3'd2, 32'h0, 0, 32'hCAFEF00D);
    idle(1);
    drain();
  endtask

  task automatic test_reset_mid_wait();
    which = 1;
    ap(1, HTRANS_NONSEQ, 1, 32'h40, 3'd2, 32'h99999999, 0, 32'h0);
    t_sel = 1'b0; t_trans = HTRANS_IDLE;
    hresetn = 1'b0;
    sb.delete();
    #1;
    n_checks += 3;
    if (o_rdy !== 1'b1) begin n_fail++; $display("FAIL midwait_reset_hreadyout: got %b, want 1", o_rdy); end
    if (o_resp !== 1'b0) begin n_fail++; $display("FAIL midwait_reset_hresp: got %b, want 0", o_resp); end
    if (o_rdata !== 32'h0) begin n_fail++; $display("FAIL midwait_reset_hrdata: got %h, want 0", o_rdata); end
    repeat (3) @(posedge hclk);
    #1 hresetn = 1'b1;
    @(posedge hclk); #1;
    ap(1, HTRANS_NONSEQ, 0, 32'h40, 3'd2, 32'h0, 0, 32'h11223344);
    idle(1);
    drain();
  endtask

  task automatic test_error();
    which = 0;
    ap(1, HTRANS_NONSEQ, 0, 32'h400, 3'd2, 32'h0, 1, 32'h0);
    ap(1, HTRANS_NONSEQ, 1, 32'h11, 3'd1, 32'hFFFF0000, 1, 32'h0);
    ap(1, HTRANS_NONSEQ, 0, 32'h10, 3'd3, 32'h0, 1, 32'h0);
    ap(1, HTRANS_NONSEQ, 0, 32'h10, 3'd2, 32'h0, 0, 32'h1234BEEF);
    idle(1);
    drain();
  endtask

  task automatic test_burst();
    logic [31:0] a;
    which = 0;
    t_burst = 3'b011;
    for (int i = 0; i < 4; i++) begin
      a = 32'h20 + 32'(4 * i);
      if (i == 2) ap(1, HTRANS_BUSY, 1, a, 3'd2, 32'h0, 0, 32'h0);
      ap(1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1, a, 3'd2, 32'hA0000000 | a, 0, 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      a = 32'h20 + 32'(4 * i);
      ap(1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 0, a, 3'd2, 32'h0, 0, 32'hA0000000 | a);
    end
    idle(1);
    drain();
    t_burst = 3'd0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_byte_half();
    test_wait_states();
    test_reset_mid_wait();
    test_error();
    test_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
AHB-Lite slave with a byte-addressable internal SRAM, a programmable number of wait states and the two-cycle ERROR response. It is the responder at the far end of the team's AHB master-side bench and driver/monitor interface. It is the synthesizable counterpart that the slave-verification environment exercises. Each beat is validated and executed independently; HBURST is informational only.

Parameters:
ADDR_W, 32, HADDR width
DATA_W, 32, HWDATA/HRDATA width (fixed 32; other values unsupported)
MEM_BYTES, 1024, SRAM size in bytes (power of 2, multiple of 4)
WAIT_STATES, 0, data-phase wait cycles per valid NONSEQ/SEQ beat (0..15)

Ports:
hclk  in  1  bus clock, all state on rising edge
hresetn  in  1  asynchronous active-low reset
hsel  in  1  slave select from decoder
haddr  in  ADDR_W  transfer address
htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
hwrite  in  1  1=write, 0=read
hsize  in  3  0=byte, 1=half, 2=word; >2 is illegal
hburst  in  3  burst type, not used for addressing
hwdata  in  DATA_W  write data, valid in data phase
hready  in  1  bus-wide HREADY (mux output)
hreadyout  out  1  slave ready
hresp  out  1  0=OKAY, 1=ERROR
hrdata  out  DATA_W  read data

Behaviour:
- Reset, asynchronous, any state: FSM goes to IDLE; hreadyout=1, hresp=0, hrdata=0; pending beat discarded, no SRAM write. SRAM contents are not cleared.
- Accept condition: hsel && hready && htrans[1]. On acceptance, latch addr, write, size and an error flag.
- hsel && hready with IDLE or BUSY: no access; next data phase is zero-wait OKAY.
- Error flag set when any of:
  - haddr >= MEM_BYTES
  - hsize > 2
  - address misaligned (half: haddr[0]!=0; word: haddr[1:0]!=0)
- FSM states:
  - IDLE: hreadyout=1, hresp=0. On accept: error → ERR1; else WAIT_STATES>0 → WAIT with cnt=WAIT_STATES-1; else → DATA.
  - WAIT: hreadyout=0, hresp=0. cnt==0 → DATA, else cnt--. New addresses are never accepted, because hready is low.
  - DATA: hreadyout=1, hresp=0. Beat completes this cycle. A new accept → same decision as IDLE; none → IDLE.
  - ERR1: hreadyout=0, hresp=1 → ERR2.
  - ERR2: hreadyout=1, hresp=1. A new accept is evaluated as in IDLE; a master cancelling with IDLE → IDLE.
- Latency: an OKAY beat takes exactly WAIT_STATES+1 data-phase cycles; an ERROR beat takes 2. Errored beats never touch the SRAM.
- Write: committed at the rising edge that ends the DATA cycle. Byte enables come from latched addr[1:0]/size, taking lanes from hwdata as AHB little-endian byte lanes.
- Read: hrdata is valid during the DATA cycle and carries the full aligned word at latched addr; the master selects the lanes. hrdata=0 in all other states.
- Back-to-back write A then read A at WAIT_STATES=0: the read returns the new data, since the write commits before the read data phase.
- hsel deasserted during own data phase: the beat still completes.

Decomposition:
- Shared package ahb_pkg:
  - htrans_e, hsize_e, hresp_e enums
  - slave state enum {IDLE, WAIT, DATA, ERR1, ERR2}
  - byte-enable function be_f(addr[1:0], size) returning 4 bits
- One sub-module, ahb_slave_mem: MEM_BYTES/4 words x 32 bits, asynchronous read, synchronous 4-bit byte-enable write, no reset.

Test Plan:
- Reset: hresetn=0 for 3 cycles, then released mid-WAIT → hreadyout=1, hresp=0, hrdata=0 immediately; memory at target address unchanged.
- WAIT_STATES=0: write word 0xDEADBEEF @0x10, then read @0x10 back-to-back → hrdata=0xDEADBEEF in the read DATA cycle, hreadyout never low.
- Byte write @0x13 with hwdata=0xAA000000, then word read @0x10 → 0xAAADBEEF; half write @0x12 with 0x12340000 → read 0x1234BEEF.
- WAIT_STATES=2: NONSEQ read → hreadyout low for exactly 2 cycles, then high with valid data; an address presented during the waits is not accepted.
- Out-of-range word read @0x400, and misaligned half write @0x11:
  - each → cycle 1 hreadyout=0/hresp=1, cycle 2 hreadyout=1/hresp=1
  - memory unchanged
  - a following NONSEQ accepted in ERR2 completes OKAY.
- INCR4 write burst 0x20..0x2C with one BUSY after beat 2 → BUSY data phase is zero-wait OKAY; all 4 words read back correctly.
